fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Owns the single framebuffer write port and shares it between two requesters: processor pixel writes (EX-stage pixel_en/pixel_value with MEM-stage address) and a hardware screen-clear engine that sweeps every pixel.
- The processor cannot be stalled, so its writes go into a small FIFO.
- A fixed-priority scheduler drains the FIFO ahead of clear traffic and drives a registered valid/ready write to the framebuffer.

Parameters:
- ADDR_W, 19, framebuffer address width.
- FB_PIXELS, 307200, number of pixels swept by a clear (640x480).
- FIFO_DEPTH, 4, processor write FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_pixel_en  in  1  processor pixel write strobe, one write per high cycle
- cpu_pixel_addr  in  32  processor pixel address; bits [ADDR_W-1:0] used
- cpu_pixel_value  in  1  processor pixel colour
- clr_req  in  1  start-clear request, sampled every cycle
- clr_value  in  1  fill colour, captured at clear start
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse when the last clear pixel has transferred
- fb_we  out  1  write valid to framebuffer
- fb_addr  out  ADDR_W  write address
- fb_data  out  1  write data
- fb_ready  in  1  framebuffer accepts; transfer = fb_we & fb_ready at a rising edge
- cpu_overflow  out  1  sticky: a processor write was dropped
- ovf_clr  in  1  synchronous clear of cpu_overflow

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; FIFO emptied; clear pointer 0; FSM to IDLE.
  - Any in-flight write is abandoned.
  - Reset mid-clear aborts the sweep with no clr_done pulse.
- FIFO:
  - Push on every cycle with cpu_pixel_en=1, storing {addr[ADDR_W-1:0], value}.
  - Full is evaluated on the pre-edge count. If full and no pop on the same edge, the push is dropped and cpu_overflow is set.
  - If full with a simultaneous pop, the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Output stage: a single register holding fb_we/fb_addr/fb_data.
  - It is free when fb_we=0 or a transfer occurs this edge.
  - While fb_we=1 and fb_ready=0, addr and data hold stable.
- FSM states:
  - IDLE: output free; FIFO non-empty loads the FIFO head (pop) into the output; else stay. clr_req=1 captures clr_value, ptr:=0, clr_busy:=1, goes to CLEAR. If clr_req and a FIFO load occur on the same edge, both happen.
  - CLEAR: on each free output slot, the FIFO head wins if non-empty; otherwise load {ptr, clr_fill} and ptr:=ptr+1. After loading ptr=FB_PIXELS-1, go to CLR_LAST.
  - CLR_LAST: FIFO writes are still served. When the last clear write transfers: clr_done=1 for one cycle, clr_busy:=0 at the same edge, go to IDLE.
- clr_req while clr_busy=1 is ignored; there is no queuing.
- Latency:
  - A processor write with an empty FIFO and free output reaches fb_we 2 cycles after the cpu_pixel_en cycle (edge 1 pushes, edge 2 loads).
  - Throughput is 1 write/cycle while fb_ready=1.
- Ordering:
  - Processor writes stay in FIFO order.
  - A processor write during a clear to an address not yet swept is overwritten by the clear. Software polls or waits for clr_busy=0 before drawing.
- cpu_overflow:
  - Set by a drop.
  - Cleared by ovf_clr; on a simultaneous drop and ovf_clr, set wins.

Optional Feature:
- Macro: FB_ADDR_CHECK_EN.
- When defined:
  - A processor write with cpu_pixel_addr >= FB_PIXELS (full 32-bit compare) is discarded at push time and never enters the FIFO.
  - Extra output addr_err (1 bit, reset 0) pulses high for the cycle after the rejected write.
- When undefined:
  - The address is truncated to ADDR_W bits and pushed unconditionally.
  - The addr_err port does not exist.

Test Plan:
- Single write: after reset, fb_ready=1, cpu_pixel_en pulse addr=0x00000123 value=1 -> fb_we=1, fb_addr=0x123, fb_data=1 exactly 2 cycles later, for 1 cycle; cpu_overflow=0.
- Backpressure/overflow (FIFO_DEPTH=4): fb_ready=0, 6 consecutive writes addr 1..6 -> output holds addr 1, FIFO holds 2..5, addr 6 dropped, cpu_overflow=1. Release fb_ready -> addrs 1..5 in order. ovf_clr -> cpu_overflow=0.
- Clear sweep (FB_PIXELS=16): clr_req pulse, clr_value=1, fb_ready=1 -> clr_busy high next cycle; addrs 0..15 data 1 on consecutive cycles; clr_done single pulse on the transfer of addr 15; clr_busy low at the same edge.
- Priority: during the clear at ptr=5, cpu write addr=9 value=0 -> processor write appears before clear addr 5; clear resumes at 5, then later writes addr 9 data 1. A second clr_req while busy has no effect: exactly 16 clear writes.
- Async reset mid-clear: rst_n low at ptr=7 with fb_ready=0 -> fb_we, clr_busy, clr_done, cpu_overflow all 0 immediately. After release, no writes occur until a new request.
- FB_ADDR_CHECK_EN (FB_PIXELS=16): write addr=16 -> no fb_we, addr_err pulses 1 cycle. Write addr=15 -> accepted, written normally.

Source files
------------

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// fb_write_arbiter : framebuffer write-port owner; processor FIFO beats clear.
// Optional macro FB_ADDR_CHECK_EN rejects out-of-range processor writes.
// Revision: 1.0
// ============================================================================
module fb_write_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int FB_PIXELS  = 307200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_pixel_en,
   input  logic [31:0]       cpu_pixel_addr,
   input  logic              cpu_pixel_value,
   input  logic              clr_req,
   input  logic              clr_value,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              fb_data,
   input  logic              fb_ready,
   output logic              cpu_overflow,
`ifdef FB_ADDR_CHECK_EN
   output logic              addr_err,
`endif
   input  logic              ovf_clr
);

   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FB_PIXELS - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CLEAR    = 2'd1,
      ST_CLR_LAST = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                fill_q, fill_d;
   logic                clr_busy_q, clr_busy_d;
   logic                clr_done_q, clr_done_d;
   logic                fb_we_q, fb_we_d;
   logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
   logic                fb_data_q, fb_data_d;
   logic                ovf_q, ovf_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];

   logic                fifo_empty;
   logic                fifo_full;
   logic                out_free;
   logic                pop;
   logic                push_req;
   logic                push_ok;
   logic                drop;
   logic [ENTRY_W-1:0]  head;

`ifdef FB_ADDR_CHECK_EN
   logic                addr_err_q, addr_err_d;
   logic                addr_bad;

   assign addr_bad   = cpu_pixel_addr >= 32'(FB_PIXELS);
   assign push_req   = cpu_pixel_en & ~addr_bad;
   assign addr_err_d = cpu_pixel_en & addr_bad;
   assign addr_err   = addr_err_q;
`else
   logic                unused_addr_hi;

   assign unused_addr_hi = ^cpu_pixel_addr[31:ADDR_W];
   assign push_req       = cpu_pixel_en;
`endif

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign out_free   = ~fb_we_q | fb_ready;
   assign pop        = out_free & ~fifo_empty;
   // Full is judged on the pre-edge count, so a same-edge pop makes room.
   assign push_ok    = push_req & (~fifo_full | pop);
   assign drop       = push_req & fifo_full & ~pop;
   assign head       = mem_q[rd_ptr_q];

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      fill_d     = fill_q;
      clr_busy_d = clr_busy_q;
      clr_done_d = 1'b0;
      fb_we_d    = fb_we_q;
      fb_addr_d  = fb_addr_q;
      fb_data_d  = fb_data_q;
      wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      ovf_d      = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

      if (fb_we_q && fb_ready) begin
         fb_we_d = 1'b0;
      end
      if (pop) begin
         fb_we_d   = 1'b1;
         fb_addr_d = head[ENTRY_W-1:1];
         fb_data_d = head[0];
      end

      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               fill_d     = clr_value;
               ptr_d      = '0;
               clr_busy_d = 1'b1;
               state_d    = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (out_free && fifo_empty) begin
               fb_we_d   = 1'b1;
               fb_addr_d = ptr_q;
               fb_data_d = fill_q;
               ptr_d     = ptr_q + 1'b1;
               if (ptr_q == LAST_PTR) begin
                  state_d = ST_CLR_LAST;
               end
            end
         end
         ST_CLR_LAST: begin
            // The output register holds the final clear pixel until it transfers.
            if (fb_we_q && fb_ready) begin
               clr_done_d = 1'b1;
               clr_busy_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         fill_q     <= 1'b0;
         clr_busy_q <= 1'b0;
         clr_done_q <= 1'b0;
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_data_q  <= 1'b0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
`ifdef FB_ADDR_CHECK_EN
         addr_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         fill_q     <= fill_d;
         clr_busy_q <= clr_busy_d;
         clr_done_q <= clr_done_d;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
`ifdef FB_ADDR_CHECK_EN
         addr_err_q <= addr_err_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= {cpu_pixel_addr[ADDR_W-1:0], cpu_pixel_value};
      end
   end

   assign clr_busy     = clr_busy_q;
   assign clr_done     = clr_done_q;
   assign fb_we        = fb_we_q;
   assign fb_addr      = fb_addr_q;
   assign fb_data      = fb_data_q;
   assign cpu_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fb_write_arbiter : directed + random bench with a queue-level model.
// Revision: 1.0
// ============================================================================
module tb_fb_write_arbiter;

   localparam int ADDR_W = 19;
   localparam int N      = 16;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic [31:0]       addr = '0;
   logic              val = 1'b0;
   logic              clr_req = 1'b0;
   logic              clr_value = 1'b0;
   logic              fb_ready = 1'b0;
   logic              ovf_clr = 1'b0;
   logic              clr_busy, clr_done, fb_we, fb_data, cpu_overflow;
   logic [ADDR_W-1:0] fb_addr;
`ifdef FB_ADDR_CHECK_EN
   logic              addr_err;
`endif

   fb_write_arbiter #(.ADDR_W(ADDR_W), .FB_PIXELS(N), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_pixel_en(en), .cpu_pixel_addr(addr), .cpu_pixel_value(val),
      .clr_req(clr_req), .clr_value(clr_value),
      .clr_busy(clr_busy), .clr_done(clr_done),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
      .cpu_overflow(cpu_overflow),
`ifdef FB_ADDR_CHECK_EN
      .addr_err(addr_err),
`endif
      .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic              d;
   } wr_t;

   // Reference model: pending processor writes, the write on the bus, and the sweep.
   wr_t mq[$];
   wr_t obs_q[$];
   wr_t m_out;
   bit  m_we, m_clearing, m_all_loaded, m_done, m_ovf, m_err, m_fill;
   int  m_next;
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_out = '0; m_we = 0; m_clearing = 0; m_all_loaded = 0;
      m_done = 0; m_ovf = 0; m_err = 0; m_fill = 0; m_next = 0;
   endtask

   task automatic model_step();
      bit xfer, free, popped, clr_load, push_req, drop, start, done_now;
      xfer     = m_we && fb_ready;
      free     = !m_we || fb_ready;
      popped   = free && (mq.size() > 0);
      clr_load = free && !popped && m_clearing && !m_all_loaded;
      start    = !m_clearing && clr_req;
      done_now = m_clearing && m_all_loaded && xfer;
`ifdef FB_ADDR_CHECK_EN
      push_req = en && (addr < N);
      m_err    = en && (addr >= N);
`else
      push_req = en;
`endif
      drop = push_req && (mq.size() == DEPTH) && !popped;
      if (popped) begin
         m_out = mq.pop_front();
         m_we  = 1;
      end else if (clr_load) begin
         m_out = '{a: ADDR_W'(m_next), d: m_fill};
         m_we  = 1;
         m_next++;
         if (m_next == N) m_all_loaded = 1;
      end else if (xfer) begin
         m_we = 0;
      end
      if (push_req && !drop) mq.push_back('{a: addr[ADDR_W-1:0], d: val});
      m_ovf  = drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      m_done = done_now;
      if (done_now) m_clearing = 0;
      if (start) begin
         m_clearing = 1; m_all_loaded = 0; m_next = 0; m_fill = clr_value;
      end
   endtask

   task automatic check_all();
      chk("fb_we", fb_we, m_we);
      if (m_we) begin
         chk("fb_addr", fb_addr, m_out.a);
         chk("fb_data", fb_data, m_out.d);
      end
      chk("clr_busy", clr_busy, m_clearing);
      chk("clr_done", clr_done, m_done);
      chk("cpu_overflow", cpu_overflow, m_ovf);
`ifdef FB_ADDR_CHECK_EN
      chk("addr_err", addr_err, m_err);
`endif
   endtask

   task automatic cycle();
      if (fb_we && fb_ready) obs_q.push_back('{a: fb_addr, d: fb_data});
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int i9, i5, i9b, n_fill;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_clr_busy", clr_busy, 0);
      chk("rst_clr_done", clr_done, 0);
      chk("rst_ovf", cpu_overflow, 0);
      rst_n = 1'b1;

      // Single write: two-cycle latency, one-cycle valid.
      fb_ready = 1; en = 1; addr = 32'h123; val = 1;
      cycle();
      en = 0;
      chk("single_lat1", fb_we, 0);
      cycle();
      chk("single_we", fb_we, 1);
      chk("single_addr", fb_addr, 32'h123);
      chk("single_data", fb_data, 1);
      chk("single_ovf", cpu_overflow, 0);
      cycle();
      chk("single_gone", fb_we, 0);

      // Backpressure: 6 writes into a 4-deep FIFO behind a stalled output.
      fb_ready = 0;
      for (int k = 1; k <= 6; k++) begin
         en = 1; addr = k; val = k[0];
         cycle();
      end
      en = 0;
      chk("ovf_set", cpu_overflow, 1);
      chk("ovf_hold_addr", fb_addr, 1);
      fb_ready = 1;
      for (int k = 1; k <= 5; k++) begin
         chk("drain_we", fb_we, 1);
         chk("drain_addr", fb_addr, k);
         cycle();
      end
      chk("drain_end", fb_we, 0);
      ovf_clr = 1;
      cycle();
      ovf_clr = 0;
      chk("ovf_cleared", cpu_overflow, 0);

      // Full clear sweep.
      obs_q.delete();
      clr_req = 1; clr_value = 1;
      cycle();
      clr_req = 0;
      chk("clr_busy_start", clr_busy, 1);
      for (int t = 0; t < 100 && clr_busy; t++) cycle();
      chk("clr_end_busy", clr_busy, 0);
      chk("clr_end_done", clr_done, 1);
      chk("clr_count", obs_q.size(), N);
      for (int i = 0; i < obs_q.size(); i++) begin
         chk("clr_seq_addr", obs_q[i].a, i);
         chk("clr_seq_data", obs_q[i].d, 1);
      end
      cycle();
      chk("clr_done_pulse", clr_done, 0);

      // Processor priority during a sweep, plus an ignored second request.
      obs_q.delete();
      clr_req = 1; clr_value = 1;
      cycle();
      clr_req = 0;
      for (int t = 0; t < 50 && !(fb_we && fb_addr == 3); t++) cycle();
      chk("prio_reach3", fb_addr, 3);
      en = 1; addr = 9; val = 0;
      cycle();
      en = 0; clr_req = 1;
      cycle();
      clr_req = 0;
      for (int t = 0; t < 100 && clr_busy; t++) cycle();
      chk("prio_end_busy", clr_busy, 0);
      i9 = -1; i5 = -1; i9b = -1; n_fill = 0;
      foreach (obs_q[i]) begin
         if (obs_q[i].d == 1) n_fill++;
         if (obs_q[i].a == 9 && obs_q[i].d == 0) i9 = i;
         if (obs_q[i].a == 5 && obs_q[i].d == 1) i5 = i;
         if (obs_q[i].a == 9 && obs_q[i].d == 1) i9b = i;
      end
      chk("prio_total", obs_q.size(), N + 1);
      chk("prio_fill_count", n_fill, N);
      chk("prio_cpu_seen", i9 >= 0, 1);
      chk("prio_cpu_before5", (i9 >= 0) && (i9 < i5), 1);
      chk("prio_clear9_after", i9b > i9, 1);
      repeat (5) cycle();

      // Async reset in the middle of a stalled sweep.
      clr_req = 1; clr_value = 0;
      cycle();
      clr_req = 0;
      for (int t = 0; t < 50 && !(fb_we && fb_addr == 7); t++) cycle();
      chk("rst_reach7", fb_addr, 7);
      fb_ready = 0;
      en = 1; addr = 3; val = 1;
      cycle();
      en = 0;
      #2 rst_n = 0;
      #1;
      chk("arst_fb_we", fb_we, 0);
      chk("arst_busy", clr_busy, 0);
      chk("arst_done", clr_done, 0);
      chk("arst_ovf", cpu_overflow, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1; fb_ready = 1;
      obs_q.delete();
      repeat (20) cycle();
      chk("arst_no_writes", obs_q.size(), 0);

`ifdef FB_ADDR_CHECK_EN
      en = 1; addr = N; val = 1;
      cycle();
      en = 0;
      chk("chk_err_pulse", addr_err, 1);
      cycle();
      chk("chk_err_gone", addr_err, 0);
      chk("chk_no_we", fb_we, 0);
      en = 1; addr = N - 1; val = 1;
      cycle();
      en = 0;
      cycle();
      chk("chk_ok_we", fb_we, 1);
      chk("chk_ok_addr", fb_addr, N - 1);
      repeat (2) cycle();
`endif

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         en        = ($urandom_range(0, 1) == 1);
         addr      = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2 * N));
         val       = 1'($urandom);
         fb_ready  = ($urandom_range(0, 9) < 7);
         clr_req   = ($urandom_range(0, 29) == 0);
         clr_value = 1'($urandom);
         ovf_clr   = ($urandom_range(0, 19) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
